combo_lock_ctrl: RTL and testbench
==================================

COMBO_LOCK_CTRL -- requirements
Module: combo_lock_ctrl

Interface
REQ-001 Parameter CODE_LEN, default 6, number of digits in the combination.
REQ-002 Parameter MAX_TRIES, default 3, failed attempts allowed before lockout.
REQ-003 Parameter LOCKOUT_CYC, default 16, lockout duration in clk cycles.
REQ-004 Parameter CODE_INIT, default 24'h012345, reset combination as BCD digits; digit 0 in bits [23:20].
REQ-005 clk  in  1  one clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 digit_in  in  4  BCD digit, sampled only when enter=1.
REQ-008 enter  in  1  one-cycle pulse; offers one digit.
REQ-009 close  in  1  one-cycle pulse; relock, abort or acknowledge.
REQ-010 prog  in  1  level; requests reprogramming, sampled with enter in OPEN.
REQ-011 state_o  out  3  current FSM state, encoded per the shared package.
REQ-012 digit_idx  out  3  number of digits accepted in the current sequence (0..CODE_LEN-1).
REQ-013 tries_left  out  2  remaining attempts.
REQ-014 unlocked  out  1  high only in OPEN and PROG.
REQ-015 err  out  1  one-cycle pulse on a rejected enter.

Function
REQ-016 FSM states: ENTRY, OPEN, FAIL, LOCKOUT, PROG; all outputs registered, one-cycle latency from the triggering pulse.
REQ-017 Invalid digit (digit_in>9) with enter shall be ignored (idx unchanged) and pulse err.
REQ-018 ENTRY: each valid enter compares digit_in with code[digit_idx], sets a sticky mismatch flag on inequality, increments digit_idx.
REQ-019 On the CODE_LEN-th valid digit, digit_idx shall wrap to 0; clean match -> OPEN with tries_left=MAX_TRIES; mismatch -> tries_left-1.
REQ-020 Failed sequence with tries_left reaching 0 -> LOCKOUT; otherwise -> FAIL.
REQ-021 FAIL: enter ignored with err pulse; close -> ENTRY with mismatch flag cleared.
REQ-022 LOCKOUT: enter ignored with err pulse; close ignored; after exactly LOCKOUT_CYC cycles -> ENTRY, tries_left=MAX_TRIES.
REQ-023 OPEN: close -> ENTRY, digit_idx=0; enter with prog=1 -> PROG, digit discarded; enter with prog=0 ignored, no err.
REQ-024 PROG: valid digits written into a shadow buffer at digit_idx; after the CODE_LEN-th digit the shadow is copied to the active code in one cycle -> OPEN.
REQ-025 close in PROG shall abort: shadow discarded, active code unchanged, -> ENTRY.
REQ-026 close in ENTRY shall clear digit_idx and the mismatch flag, tries_left unchanged.
REQ-027 enter and close in the same cycle: close takes priority, enter dropped without err.

Reset
REQ-028 While rst_n=0 at a clk edge: state=ENTRY, digit_idx=0, tries_left=MAX_TRIES, mismatch clear, err=0, unlocked=0, lockout counter 0, active code=CODE_INIT.
REQ-029 Reset mid-PROG or mid-LOCKOUT shall restore CODE_INIT and end lockout immediately; no inputs are honored in the reset cycle.

Structure
REQ-030 Package combo_pkg holds the state enum, BCD digit typedef and default parameters.
REQ-031 The lockout counter shall be a sub-module lockout_timer (start pulse, done pulse, LOCKOUT_CYC parameter).
REQ-032 Active code and shadow buffer are CODE_LEN x 4-bit register arrays within combo_lock_ctrl.

Verification
REQ-033 Reset, enter 0,1,2,3,4,5 -> unlocked=1 one cycle after the 6th pulse, tries_left=3.
REQ-034 Enter 0,1,2,3,4,6 three times with close between -> FAIL, FAIL, then LOCKOUT; unlocked stays 0 for 16 cycles, then ENTRY with tries_left=3.
REQ-035 In OPEN, enter with prog=1, then 9,8,7,6,5,4, close, enter 9,8,7,6,5,4 -> unlocked=1; old code 012345 fails.
REQ-036 In PROG after 3 digits, close -> ENTRY; code 012345 still opens.
REQ-037 digit_in=4'hC with enter in ENTRY -> err pulse, digit_idx unchanged; enter+close same cycle -> digit_idx=0, err=0.
REQ-038 rst_n low during LOCKOUT -> next cycle ENTRY, tries_left=3, code 012345 opens.

Source files
------------

// File: rtl/combo_pkg.sv
// Shared types and default parameters for the combination lock controller.
package combo_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_OPEN    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_PROG    = 3'd4
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam int          CODE_LEN_DEF    = 6;
  localparam int          MAX_TRIES_DEF   = 3;
  localparam int          LOCKOUT_CYC_DEF = 16;
  localparam logic [23:0] CODE_INIT_DEF   = 24'h012345;

endpackage

// File: rtl/lockout_timer.sv
// One-shot down-counter: done_o fires in the LOCKOUT_CYC-th cycle after start_i.
module lockout_timer #(
  parameter int LOCKOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  output logic done_o
);

  localparam int CW = $clog2(LOCKOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i)             cnt_d = CW'(LOCKOUT_CYC);
    else if (cnt_q != '0)    cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Loaded on the edge entering lockout, so the last count lands on the exit edge.
  assign done_o = (cnt_q == CW'(1));

endmodule

// File: rtl/combo_lock_ctrl.sv
// Digit-entry combination lock with retry limit, timed lockout and reprogramming.
module combo_lock_ctrl
  import combo_pkg::*;
#(
  parameter int                      CODE_LEN    = CODE_LEN_DEF,
  parameter int                      MAX_TRIES   = MAX_TRIES_DEF,
  parameter int                      LOCKOUT_CYC = LOCKOUT_CYC_DEF,
  parameter logic [4*CODE_LEN-1:0]   CODE_INIT   = CODE_INIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_in,
  input  logic       enter,
  input  logic       close,
  input  logic       prog,
  output logic [2:0] state_o,
  output logic [2:0] digit_idx,
  output logic [1:0] tries_left,
  output logic       unlocked,
  output logic       err
);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [1:0] tries_q, tries_d;
  logic       mism_q, mism_d;
  logic       err_q, err_d;
  logic       unl_q, unl_d;
  bcd_t       code_q   [CODE_LEN];
  bcd_t       code_d   [CODE_LEN];
  bcd_t       shadow_q [CODE_LEN];
  bcd_t       shadow_d [CODE_LEN];

  logic       tmr_start, tmr_done;
  logic       dig_ok, last_dig, mism_n;

  lockout_timer #(.LOCKOUT_CYC(LOCKOUT_CYC)) u_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(tmr_start),
    .done_o (tmr_done)
  );

  assign dig_ok   = (digit_in <= 4'd9);
  assign last_dig = (idx_q == 3'(CODE_LEN - 1));
  assign mism_n   = mism_q | (digit_in != code_q[idx_q]);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tries_d   = tries_q;
    mism_d    = mism_q;
    err_d     = 1'b0;
    tmr_start = 1'b0;
    code_d    = code_q;
    shadow_d  = shadow_q;

    unique case (state_q)
      ST_ENTRY: begin
        if (close) begin
          idx_d  = '0;
          mism_d = 1'b0;
        end else if (enter) begin
          if (!dig_ok) begin
            err_d = 1'b1;
          end else if (!last_dig) begin
            idx_d  = idx_q + 3'd1;
            mism_d = mism_n;
          end else begin
            idx_d = '0;
            if (!mism_n) begin
              state_d = ST_OPEN;
              tries_d = 2'(MAX_TRIES);
              mism_d  = 1'b0;
            end else begin
              tries_d = tries_q - 2'd1;
              mism_d  = 1'b1;
              if (tries_q == 2'd1) begin
                state_d   = ST_LOCKOUT;
                tmr_start = 1'b1;
              end else begin
                state_d = ST_FAIL;
              end
            end
          end
        end
      end

      ST_OPEN: begin
        if (close) begin
          state_d = ST_ENTRY;
          idx_d   = '0;
          mism_d  = 1'b0;
        end else if (enter && prog) begin
          state_d = ST_PROG;
          idx_d   = '0;
        end
      end

      ST_FAIL: begin
        if (close) begin
          state_d = ST_ENTRY;
          idx_d   = '0;
          mism_d  = 1'b0;
        end else if (enter) begin
          err_d = 1'b1;
        end
      end

      ST_LOCKOUT: begin
        if (!close && enter) err_d = 1'b1;
        if (tmr_done) begin
          state_d = ST_ENTRY;
          tries_d = 2'(MAX_TRIES);
          idx_d   = '0;
          mism_d  = 1'b0;
        end
      end

      ST_PROG: begin
        if (close) begin
          state_d = ST_ENTRY;
          idx_d   = '0;
          mism_d  = 1'b0;
        end else if (enter) begin
          if (!dig_ok) begin
            err_d = 1'b1;
          end else begin
            shadow_d[idx_q] = digit_in;
            if (last_dig) begin
              // Commit the whole shadow, including the digit arriving this cycle.
              for (int i = 0; i < CODE_LEN; i++)
                code_d[i] = (3'(i) == idx_q) ? digit_in : shadow_q[i];
              state_d = ST_OPEN;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
      end

      default: state_d = ST_ENTRY;
    endcase

    unl_d = (state_d == ST_OPEN) || (state_d == ST_PROG);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ENTRY;
      idx_q   <= '0;
      tries_q <= 2'(MAX_TRIES);
      mism_q  <= 1'b0;
      err_q   <= 1'b0;
      unl_q   <= 1'b0;
      for (int i = 0; i < CODE_LEN; i++) begin
        code_q[i]   <= CODE_INIT[4*(CODE_LEN-1-i) +: 4];
        shadow_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tries_q  <= tries_d;
      mism_q   <= mism_d;
      err_q    <= err_d;
      unl_q    <= unl_d;
      code_q   <= code_d;
      shadow_q <= shadow_d;
    end
  end

  assign state_o    = state_q;
  assign digit_idx  = idx_q;
  assign tries_left = tries_q;
  assign unlocked   = unl_q;
  assign err        = err_q;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Directed bench for combo_lock_ctrl; inputs driven and outputs sampled on negedge.
module tb_combo_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] digit_in;
  logic       enter, close, prog;
  logic [2:0] state_o, digit_idx;
  logic [1:0] tries_left;
  logic       unlocked, err;

  int n_chk  = 0;
  int n_pass = 0;

  localparam int S_ENTRY = 0, S_OPEN = 1, S_FAIL = 2, S_LOCK = 3, S_PROG = 4;

  combo_lock_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digit_in  (digit_in),
    .enter     (enter),
    .close     (close),
    .prog      (prog),
    .state_o   (state_o),
    .digit_idx (digit_idx),
    .tries_left(tries_left),
    .unlocked  (unlocked),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // All stimulus tasks start and end at a negedge.
  task automatic key(input logic [3:0] d);
    digit_in = d; enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
  endtask

  task automatic keys(input logic [23:0] c);
    for (int i = 0; i < 6; i++) key(c[23-4*i -: 4]);
  endtask

  task automatic clos();
    close = 1'b1;
    @(negedge clk);
    close = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; digit_in = '0; enter = 1'b0; close = 1'b0; prog = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_state", state_o, S_ENTRY);
    chk("rst_idx", digit_idx, 0);
    chk("rst_tries", tries_left, 3);
    chk("rst_unl", unlocked, 0);
    chk("rst_err", err, 0);

    // correct code opens
    for (int i = 0; i < 6; i++) begin
      chk("pre_open_unl", unlocked, 0);
      key(4'(i));
      if (i == 2) chk("mid_idx", digit_idx, 3);
    end
    chk("open_unl", unlocked, 1);
    chk("open_state", state_o, S_OPEN);
    chk("open_tries", tries_left, 3);
    chk("open_idx", digit_idx, 0);
    key(4'd7);
    chk("open_enter_noerr", err, 0);
    chk("open_enter_stay", state_o, S_OPEN);
    clos();
    chk("relock_state", state_o, S_ENTRY);
    chk("relock_unl", unlocked, 0);

    // three wrong sequences -> lockout
    keys(24'h012346);
    chk("fail1_state", state_o, S_FAIL);
    chk("fail1_tries", tries_left, 2);
    key(4'd1);
    chk("fail_enter_err", err, 1);
    chk("fail_enter_stay", state_o, S_FAIL);
    clos();
    chk("fail_close", state_o, S_ENTRY);
    keys(24'h012346);
    chk("fail2_state", state_o, S_FAIL);
    chk("fail2_tries", tries_left, 1);
    clos();
    keys(24'h012346);
    chk("lock_state", state_o, S_LOCK);
    chk("lock_tries", tries_left, 0);
    for (int i = 1; i < 16; i++) begin
      if (i == 3) begin digit_in = 4'd1; enter = 1'b1; end
      if (i == 5) close = 1'b1;
      @(negedge clk);
      enter = 1'b0; close = 1'b0;
      chk("lock_hold", state_o, S_LOCK);
      chk("lock_unl", unlocked, 0);
      if (i == 3) chk("lock_err", err, 1);
    end
    @(negedge clk);
    chk("lock_exit_state", state_o, S_ENTRY);
    chk("lock_exit_tries", tries_left, 3);

    // reprogram to 987654
    keys(24'h012345);
    chk("open2", state_o, S_OPEN);
    prog = 1'b1;
    key(4'd0);
    prog = 1'b0;
    chk("prog_state", state_o, S_PROG);
    chk("prog_unl", unlocked, 1);
    keys(24'h987654);
    chk("prog_done_state", state_o, S_OPEN);
    chk("prog_done_unl", unlocked, 1);
    clos();
    keys(24'h987654);
    chk("new_code_opens", unlocked, 1);
    clos();
    keys(24'h012345);
    chk("old_code_fails", state_o, S_FAIL);
    chk("old_code_tries", tries_left, 2);
    clos();
    keys(24'h012346);
    clos();
    keys(24'h012346);
    chk("lock2_state", state_o, S_LOCK);

    // reset mid-lockout restores defaults and initial code
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_lock_state", state_o, S_ENTRY);
    chk("rst_lock_tries", tries_left, 3);
    keys(24'h012345);
    chk("rst_code_opens", unlocked, 1);

    // program abort keeps old code
    prog = 1'b1;
    key(4'd0);
    prog = 1'b0;
    key(4'd1); key(4'd1); key(4'd1);
    chk("abort_idx", digit_idx, 3);
    clos();
    chk("abort_state", state_o, S_ENTRY);
    chk("abort_unl", unlocked, 0);
    chk("abort_idx0", digit_idx, 0);
    keys(24'h012345);
    chk("abort_code_opens", unlocked, 1);
    clos();

    // invalid digit, then enter+close collision
    key(4'd0);
    chk("inv_pre_idx", digit_idx, 1);
    key(4'hC);
    chk("inv_err", err, 1);
    chk("inv_idx", digit_idx, 1);
    digit_in = 4'd2; enter = 1'b1; close = 1'b1;
    @(negedge clk);
    enter = 1'b0; close = 1'b0;
    chk("coll_idx", digit_idx, 0);
    chk("coll_err", err, 0);
    chk("coll_state", state_o, S_ENTRY);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
